br_issue_queue: RTL

- In-order issue queue that buffers branch/jump micro-ops from dispatch and snoops the CDB (common data bus) to wake up pending source operands.
- Issues the oldest entry to the combinational branch functional unit once both of its operands are ready.
- Sits between rename/dispatch and the branch FU.
- The issue outputs are registered and drive the branch FU's br_issue_* inputs directly.

---
 rtl/br_issue_queue_pkg.sv | 31 +++
 rtl/br_iq_operand_wakeup.sv | 47 ++++
 rtl/br_issue_queue.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/br_issue_queue_pkg.sv
// Shared widths, branch opcode encodings and the per-entry payload type for the branch issue queue.
`ifndef BR_ISSUE_QUEUE_DEFS
`define BR_ISSUE_QUEUE_DEFS
`define DATA_WIDTH_BR_OP 3
`define PC_WIDTH 32
`define WORD_WIDTH 32
`define ROB_DEPTH 16
`endif

package br_issue_queue_pkg;
    localparam int unsigned OP_W      = `DATA_WIDTH_BR_OP;
    localparam int unsigned PC_W      = `PC_WIDTH;
    localparam int unsigned WORD_W    = `WORD_WIDTH;
    localparam int unsigned ROB_TAG_W = $clog2(`ROB_DEPTH);

    localparam logic [OP_W-1:0] BR_OP_BEQ  = OP_W'(0);
    localparam logic [OP_W-1:0] BR_OP_BNE  = OP_W'(1);
    localparam logic [OP_W-1:0] BR_OP_BLT  = OP_W'(2);
    localparam logic [OP_W-1:0] BR_OP_BGE  = OP_W'(3);
    localparam logic [OP_W-1:0] BR_OP_BLTU = OP_W'(4);
    localparam logic [OP_W-1:0] BR_OP_BGEU = OP_W'(5);
    localparam logic [OP_W-1:0] BR_OP_JAL  = OP_W'(6);
    localparam logic [OP_W-1:0] BR_OP_JALR = OP_W'(7);

    // Operand-independent fields of a queued branch.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [PC_W-1:0]   pc;
        logic [WORD_W-1:0] imm;
    } br_payload_t;
endpackage

// File: rtl/br_iq_operand_wakeup.sv
// One source operand slot of an issue-queue entry: holds ready/tag/value and captures CDB results.
module br_iq_operand_wakeup
    import br_issue_queue_pkg::*;
#(
    parameter int unsigned TAG_W  = ROB_TAG_W,
    parameter bit          BYPASS = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_ready,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_value,
    input  logic              cdb_en,
    input  logic [TAG_W-1:0]  cdb_rob,
    input  logic [WORD_W-1:0] cdb_value,
    output logic              ready_c,
    output logic [WORD_W-1:0] value_c
);
    logic              ready;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] value;
    logic              wr_hit_c;
    logic              hit_c;

    assign wr_hit_c = cdb_en && !wr_ready && (wr_tag == cdb_rob);
    assign hit_c    = cdb_en && !ready && (tag == cdb_rob);

    // Dispatch overwrites the slot; otherwise a pending operand waits for its tag on the CDB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b0;
            tag   <= '0;
            value <= '0;
        end else if (wr_en) begin
            ready <= wr_ready || wr_hit_c;
            tag   <= wr_tag;
            value <= wr_hit_c ? cdb_value : wr_value;
        end else if (hit_c) begin
            ready <= 1'b1;
            value <= cdb_value;
        end
    end

    assign ready_c = ready || (BYPASS && hit_c);
    assign value_c = (BYPASS && hit_c) ? cdb_value : value;
endmodule

// File: rtl/br_issue_queue.sv
// In-order branch issue queue with CDB wakeup. Define BR_IQ_CDB_BYPASS_EN to let the head
// entry issue on the same edge as the broadcast that completes its operands.
module br_issue_queue
    import br_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = $clog2(`ROB_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dispatch_en,
    input  logic [`DATA_WIDTH_BR_OP-1:0] dispatch_op,
    input  logic [`PC_WIDTH-1:0]         dispatch_pc,
    input  logic [`WORD_WIDTH-1:0]       dispatch_imm,
    input  logic                         dispatch_rs1_ready,
    input  logic [TAG_W-1:0]             dispatch_rs1_tag,
    input  logic [`WORD_WIDTH-1:0]       dispatch_rs1_value,
    input  logic                         dispatch_rs2_ready,
    input  logic [TAG_W-1:0]             dispatch_rs2_tag,
    input  logic [`WORD_WIDTH-1:0]       dispatch_rs2_value,
    input  logic [TAG_W-1:0]             dispatch_Pdst,
    output logic                         br_iq_full,
    input  logic                         cdb_en,
    input  logic [TAG_W-1:0]             cdb_rob,
    input  logic [`WORD_WIDTH-1:0]       cdb_value,
    input  logic                         flush,
    output logic                         br_issue_en,
    output logic [`DATA_WIDTH_BR_OP-1:0] br_issue_queue_op,
    output logic [`PC_WIDTH-1:0]         br_issue_queue_pc,
    output logic [`WORD_WIDTH-1:0]       br_issue_queue_imm,
    output logic [`WORD_WIDTH-1:0]       br_issue_queue_rs1_value,
    output logic [`WORD_WIDTH-1:0]       br_issue_queue_rs2_value,
    output logic [TAG_W-1:0]             br_issue_queue_Pdst
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
`ifdef BR_IQ_CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              valid       [DEPTH];
    br_payload_t       payload     [DEPTH];
    logic [TAG_W-1:0]  pdst        [DEPTH];
    logic              rs1_ready_c [DEPTH];
    logic              rs2_ready_c [DEPTH];
    logic [WORD_W-1:0] rs1_value_c [DEPTH];
    logic [WORD_W-1:0] rs2_value_c [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n_c;
    logic              push_c;
    logic              issue_c;

    assign push_c    = dispatch_en && !br_iq_full && !flush;
    assign issue_c   = valid[head] && rs1_ready_c[head] && rs2_ready_c[head];
    assign count_n_c = count + CNT_W'(push_c) - CNT_W'(issue_c);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic wr_c;
        assign wr_c = push_c && (tail == PTR_W'(i));

        br_iq_operand_wakeup #(.TAG_W(TAG_W), .BYPASS(BYPASS)) u_rs1 (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_c),
            .wr_ready  (dispatch_rs1_ready),
            .wr_tag    (dispatch_rs1_tag),
            .wr_value  (dispatch_rs1_value),
            .cdb_en    (cdb_en),
            .cdb_rob   (cdb_rob),
            .cdb_value (cdb_value),
            .ready_c   (rs1_ready_c[i]),
            .value_c   (rs1_value_c[i])
        );

        br_iq_operand_wakeup #(.TAG_W(TAG_W), .BYPASS(BYPASS)) u_rs2 (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_c),
            .wr_ready  (dispatch_rs2_ready),
            .wr_tag    (dispatch_rs2_tag),
            .wr_value  (dispatch_rs2_value),
            .cdb_en    (cdb_en),
            .cdb_rob   (cdb_rob),
            .cdb_value (cdb_value),
            .ready_c   (rs2_ready_c[i]),
            .value_c   (rs2_value_c[i])
        );
    end

    // Queue bookkeeping and issue registers; flush wins over dispatch and issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid[i]   <= 1'b0;
                payload[i] <= '0;
                pdst[i]    <= '0;
            end
            head                     <= '0;
            tail                     <= '0;
            count                    <= '0;
            br_iq_full               <= 1'b0;
            br_issue_en              <= 1'b0;
            br_issue_queue_op        <= '0;
            br_issue_queue_pc        <= '0;
            br_issue_queue_imm       <= '0;
            br_issue_queue_rs1_value <= '0;
            br_issue_queue_rs2_value <= '0;
            br_issue_queue_Pdst      <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid[i] <= 1'b0;
            end
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            br_iq_full  <= 1'b0;
            br_issue_en <= 1'b0;
        end else begin
            if (push_c) begin
                valid[tail]   <= 1'b1;
                payload[tail] <= '{op: dispatch_op, pc: dispatch_pc, imm: dispatch_imm};
                pdst[tail]    <= dispatch_Pdst;
                tail          <= tail + PTR_W'(1);
            end
            if (issue_c) begin
                valid[head]              <= 1'b0;
                head                     <= head + PTR_W'(1);
                br_issue_queue_op        <= payload[head].op;
                br_issue_queue_pc        <= payload[head].pc;
                br_issue_queue_imm       <= payload[head].imm;
                br_issue_queue_rs1_value <= rs1_value_c[head];
                br_issue_queue_rs2_value <= rs2_value_c[head];
                br_issue_queue_Pdst      <= pdst[head];
            end
            br_issue_en <= issue_c;
            count       <= count_n_c;
            br_iq_full  <= (count_n_c == CNT_W'(DEPTH));
        end
    end
endmodule
